axis_traffic_gen: RTL and testbench

- Synthetic AXI-Stream packet source that drives the injection port (axis_in_*) of one router wrapper in the sweep harness.
- Emits a programmable number of multi-flit packets with fixed or pseudo-random destinations, optional inter-packet gaps, and self-describing payloads that a downstream checker can validate.
- Lives in the user clock domain, directly upstream of the router wrapper's serializer shim.

---
 rtl/noc_tg_pkg.sv | 26 ++
 rtl/lfsr16.sv | 22 ++
 rtl/axis_traffic_gen.sv | 207 ++++++++++++++++++++
 tb/tb_axis_traffic_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_tg_pkg.sv
// Shared types and constants for the AXI-Stream traffic generator.
// Field offsets describe the self-describing payload seen by downstream checkers.
package noc_tg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_GAP,
      ST_DONE
   } tg_state_e;

   localparam int SEQ_LSB = 48;
   localparam int SEQ_W   = 16;
   localparam int IDX_LSB = 40;
   localparam int IDX_W   = 8;
   localparam int SRC_LSB = 32;
   localparam int SRC_W   = 8;
   localparam int TS_LSB  = 0;
   localparam int TS_W    = 32;

   // Fibonacci taps 16,14,13,11 expressed on a right-shifting register (bits 0,2,3,5).
   localparam logic [15:0] LFSR_TAP_MASK     = 16'h002D;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step per cycle while step is high.
// The seed must be nonzero; the all-zero state is a lock-up state.
module lfsr16
   import noc_tg_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step,
   output logic [15:0] state
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEED;
      end else if (step) begin
         state <= {^(state & LFSR_TAP_MASK), state[15:1]};
      end
   end

endmodule

// File: rtl/axis_traffic_gen.sv
// Synthetic AXI-Stream packet source with fixed or LFSR destinations,
// inter-packet gaps and payloads carrying seq/index/source/timestamp.
//
// state | meaning
// IDLE  | waiting for enable; run settings latched on exit
// LOAD  | pick destination, capture timestamp, step LFSR
// SEND  | presenting flits, tvalid high
// GAP   | idle cycles after a packet, tvalid low
// DONE  | run finished, done high until enable drops
module axis_traffic_gen
   import noc_tg_pkg::*;
#(
   parameter int          TDATA_WIDTH       = 64,
   parameter int          TDEST_WIDTH       = 4,
   parameter int          TID_WIDTH         = 2,
   parameter int          NOC_NUM_ENDPOINTS = 16,
   parameter int          SRC_ID            = 0,
   parameter int          MAX_PKT_LEN       = 16,
   parameter logic [15:0] LFSR_SEED         = 16'hACE1,
   localparam int         LEN_W             = $clog2(MAX_PKT_LEN + 1)
) (
   input  logic                   clk_usr,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [15:0]            num_packets,
   input  logic [LEN_W-1:0]       pkt_len,
   input  logic                   rand_dest,
   input  logic [TDEST_WIDTH-1:0] fixed_dest,
   input  logic [7:0]             gap_cycles,
   output logic                   axis_out_tvalid,
   input  logic                   axis_out_tready,
   output logic [TDATA_WIDTH-1:0] axis_out_tdata,
   output logic                   axis_out_tlast,
   output logic [TID_WIDTH-1:0]   axis_out_tid,
   output logic [TDEST_WIDTH-1:0] axis_out_tdest,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            pkts_sent,
   output logic [31:0]            stall_cycles
);

   localparam int DEST_IDX_W = $clog2(NOC_NUM_ENDPOINTS);

   tg_state_e              state;
   logic [15:0]            num_q;
   logic [LEN_W-1:0]       len_q;
   logic                   rand_q;
   logic [TDEST_WIDTH-1:0] fixed_q;
   logic [7:0]             gap_q;
   logic [7:0]             gap_cnt;
   logic [15:0]            seq;
   logic [LEN_W-1:0]       idx;
   logic [31:0]            ts_q;
   logic [31:0]            cycle_cnt;
   logic [TDEST_WIDTH-1:0] dest_q;
   logic                   tvalid_q;
   logic                   done_q;
   logic [15:0]            lfsr_q;
   logic [LEN_W-1:0]       len_clamped;
   logic [TDEST_WIDTH-1:0] rnd_dest;
   logic                   last_flit;
   logic                   hs;
   logic                   unused_lfsr;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk_usr),
      .rst_n (rst_n),
      .step  (state == ST_LOAD),
      .state (lfsr_q)
   );

   assign unused_lfsr = ^lfsr_q[15:DEST_IDX_W];

   always_comb begin
      len_clamped = pkt_len;
      if (pkt_len == '0) begin
         len_clamped = LEN_W'(1);
      end else if (pkt_len > LEN_W'(MAX_PKT_LEN)) begin
         len_clamped = LEN_W'(MAX_PKT_LEN);
      end
   end

   // Never target ourselves: bump to the next endpoint, wrapping within the endpoint range.
   always_comb begin
      rnd_dest = '0;
      rnd_dest[DEST_IDX_W-1:0] = lfsr_q[DEST_IDX_W-1:0];
      if (rnd_dest == TDEST_WIDTH'(SRC_ID)) begin
         rnd_dest[DEST_IDX_W-1:0] = lfsr_q[DEST_IDX_W-1:0] + 1'b1;
      end
   end

   assign last_flit = (idx == len_q - 1'b1);
   assign hs        = tvalid_q & axis_out_tready;

   always_ff @(posedge clk_usr or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk_usr or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         num_q        <= '0;
         len_q        <= '0;
         rand_q       <= 1'b0;
         fixed_q      <= '0;
         gap_q        <= '0;
         gap_cnt      <= '0;
         seq          <= '0;
         idx          <= '0;
         ts_q         <= '0;
         dest_q       <= '0;
         tvalid_q     <= 1'b0;
         done_q       <= 1'b0;
         pkts_sent    <= '0;
         stall_cycles <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  num_q        <= num_packets;
                  len_q        <= len_clamped;
                  rand_q       <= rand_dest;
                  fixed_q      <= fixed_dest;
                  gap_q        <= gap_cycles;
                  pkts_sent    <= '0;
                  stall_cycles <= '0;
                  seq          <= '0;
                  if (num_packets == '0) begin
                     state  <= ST_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               dest_q   <= rand_q ? rnd_dest : fixed_q;
               ts_q     <= cycle_cnt;
               idx      <= '0;
               tvalid_q <= 1'b1;
               state    <= ST_SEND;
            end
            ST_SEND: begin
               if (!axis_out_tready && stall_cycles != '1) begin
                  stall_cycles <= stall_cycles + 32'd1;
               end
               if (hs) begin
                  if (!last_flit) begin
                     idx <= idx + 1'b1;
                  end else begin
                     pkts_sent <= pkts_sent + 16'd1;
                     seq       <= seq + 16'd1;
                     tvalid_q  <= 1'b0;
                     if (pkts_sent + 16'd1 == num_q) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                     end else if (!enable) begin
                        state <= ST_IDLE;
                     end else if (gap_q != '0) begin
                        gap_cnt <= gap_q;
                        state   <= ST_GAP;
                     end else begin
                        state <= ST_LOAD;
                     end
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt == 8'd1) begin
                  state <= enable ? ST_LOAD : ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end
            ST_DONE: begin
               if (!enable) begin
                  state  <= ST_IDLE;
                  done_q <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      axis_out_tdata = '0;
      if (tvalid_q) begin
         axis_out_tdata[SEQ_LSB +: SEQ_W] = seq;
         axis_out_tdata[IDX_LSB +: IDX_W] = IDX_W'(idx);
         axis_out_tdata[SRC_LSB +: SRC_W] = SRC_W'(SRC_ID);
         axis_out_tdata[TS_LSB +: TS_W]   = ts_q;
      end
   end

   assign axis_out_tvalid = tvalid_q;
   assign axis_out_tlast  = tvalid_q & last_flit;
   assign axis_out_tid    = tvalid_q ? seq[TID_WIDTH-1:0] : '0;
   assign axis_out_tdest  = tvalid_q ? dest_q : '0;
   assign busy            = (state != ST_IDLE) && (state != ST_DONE);
   assign done            = done_q;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Bench for axis_traffic_gen: randomized runs checked flit-by-flit against a
// packet-level reference model (expected seq/index/timestamp/destination per flit).
module tb_axis_traffic_gen;

   localparam int TDW  = 64;
   localparam int MAXL = 16;
   localparam int SRC  = 3;
   localparam int LW   = 5;

   logic        clk_usr = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] num_packets = '0;
   logic [LW-1:0] pkt_len = '0;
   logic        rand_dest = 1'b0;
   logic [3:0]  fixed_dest = '0;
   logic [7:0]  gap_cycles = '0;
   logic        axis_out_tready = 1'b0;
   logic        axis_out_tvalid;
   logic [TDW-1:0] axis_out_tdata;
   logic        axis_out_tlast;
   logic [1:0]  axis_out_tid;
   logic [3:0]  axis_out_tdest;
   logic        busy;
   logic        done;
   logic [15:0] pkts_sent;
   logic [31:0] stall_cycles;

   int checks = 0;
   int failures = 0;
   int unsigned cyc;
   logic [15:0] model_lfsr = 16'hACE1;

   axis_traffic_gen #(
      .TDATA_WIDTH(TDW), .TDEST_WIDTH(4), .TID_WIDTH(2), .NOC_NUM_ENDPOINTS(16),
      .SRC_ID(SRC), .MAX_PKT_LEN(MAXL), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk_usr(clk_usr), .rst_n(rst_n), .enable(enable), .num_packets(num_packets),
      .pkt_len(pkt_len), .rand_dest(rand_dest), .fixed_dest(fixed_dest),
      .gap_cycles(gap_cycles), .axis_out_tvalid(axis_out_tvalid),
      .axis_out_tready(axis_out_tready), .axis_out_tdata(axis_out_tdata),
      .axis_out_tlast(axis_out_tlast), .axis_out_tid(axis_out_tid),
      .axis_out_tdest(axis_out_tdest), .busy(busy), .done(done),
      .pkts_sent(pkts_sent), .stall_cycles(stall_cycles)
   );

   always #5 clk_usr = ~clk_usr;

   // Elapsed clock edges since reset release: the generator's timestamp base.
   always @(posedge clk_usr or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   function automatic logic [3:0] model_dest(input logic [15:0] s);
      logic [3:0] d;
      d = s[3:0];
      if (d == 4'(SRC)) d = d + 4'd1;
      return d;
   endfunction

   // rmode: 0 = always ready, 1 = random ready, 2 = ready held low 5 cycles after first handshake
   task automatic run_pkts(input string name, input int n, input int len, input bit rd,
                           input logic [3:0] fd, input int gap, input int rmode, input int drop_at);
      int eff, exp_pk, exp_idx, hs_cnt, idle, stalls, hold;
      bit started, dropped, finished, rdy;
      logic [31:0] ts;
      logic [3:0] dst;
      logic [63:0] exp_data;
      eff = (len == 0) ? 1 : ((len > MAXL) ? MAXL : len);
      exp_pk = 0; exp_idx = 0; hs_cnt = 0; stalls = 0; hold = 0;
      started = 0; dropped = 0; finished = 0; ts = '0; dst = '0;
      num_packets = 16'(n); pkt_len = LW'(len); rand_dest = rd; fixed_dest = fd;
      gap_cycles = 8'(gap); axis_out_tready = 1'b1; enable = 1'b1;
      @(posedge clk_usr); #1;
      // Settings must already be latched: scramble the inputs.
      num_packets = 16'($urandom); pkt_len = LW'($urandom); rand_dest = 1'($urandom);
      fixed_dest = 4'($urandom); gap_cycles = 8'($urandom);
      checks++; if (pkts_sent !== 16'd0) begin failures++; $display("FAIL %s start_pkts_sent got=%0d exp=0", name, pkts_sent); end
      checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL %s start_stall got=%0d exp=0", name, stall_cycles); end
      checks++; if (done !== (n == 0)) begin failures++; $display("FAIL %s start_done got=%0b exp=%0b", name, done, (n == 0)); end
      checks++; if (busy !== (n != 0)) begin failures++; $display("FAIL %s start_busy got=%0b exp=%0b", name, busy, (n != 0)); end
      checks++; if (axis_out_tvalid !== 1'b0) begin failures++; $display("FAIL %s start_tvalid got=%0b exp=0", name, axis_out_tvalid); end
      idle = 1;
      if (n == 0) finished = 1;
      for (int c = 0; c < 6000 && !finished; c++) begin
         @(posedge clk_usr); #1;
         case (rmode)
            0: rdy = 1'b1;
            1: rdy = ($urandom_range(0, 3) != 0);
            default: rdy = (hold == 0);
         endcase
         axis_out_tready = rdy;
         if (axis_out_tvalid) begin
            if (!started) begin
               started = 1;
               checks++;
               if (idle != ((exp_pk == 0) ? 1 : gap + 1)) begin
                  failures++;
                  $display("FAIL %s idle_before_pkt%0d got=%0d exp=%0d", name, exp_pk, idle, (exp_pk == 0) ? 1 : gap + 1);
               end
               checks++; if (exp_pk >= n) begin failures++; $display("FAIL %s extra_packet got=%0d exp<%0d", name, exp_pk, n); end
               ts = 32'(cyc - 1);
               dst = rd ? model_dest(model_lfsr) : fd;
               model_lfsr = lfsr_next(model_lfsr);
            end
            exp_data = {16'(exp_pk), 8'(exp_idx), 8'(SRC), ts};
            checks++; if (axis_out_tdata !== exp_data) begin failures++; $display("FAIL %s tdata p%0d f%0d got=%h exp=%h", name, exp_pk, exp_idx, axis_out_tdata, exp_data); end
            checks++; if (axis_out_tlast !== (exp_idx == eff - 1)) begin failures++; $display("FAIL %s tlast p%0d f%0d got=%0b exp=%0b", name, exp_pk, exp_idx, axis_out_tlast, (exp_idx == eff - 1)); end
            checks++; if (axis_out_tdest !== dst) begin failures++; $display("FAIL %s tdest p%0d got=%0d exp=%0d", name, exp_pk, axis_out_tdest, dst); end
            checks++; if (axis_out_tid !== 2'(exp_pk)) begin failures++; $display("FAIL %s tid p%0d got=%0d exp=%0d", name, exp_pk, axis_out_tid, 2'(exp_pk)); end
            if (rd) begin
               checks++; if (axis_out_tdest === 4'(SRC)) begin failures++; $display("FAIL %s tdest_self got=%0d exp!=%0d", name, axis_out_tdest, SRC); end
            end
            if (!rdy) begin
               stalls++;
               if (hold > 0) hold--;
            end else begin
               hs_cnt++;
               if (rmode == 2 && hs_cnt == 1) hold = 5;
               if (hs_cnt == drop_at) begin enable = 1'b0; dropped = 1; end
               if (exp_idx == eff - 1) begin
                  exp_pk++; exp_idx = 0; started = 0; idle = 0;
                  if (dropped) finished = 1;
               end else begin
                  exp_idx++;
               end
            end
         end else begin
            idle++;
            if (done) finished = 1;
         end
      end
      checks++; if (!finished) begin failures++; $display("FAIL %s timeout got=%0d pkts exp=%0d", name, exp_pk, n); end
      if (dropped) begin
         repeat (3) begin
            @(posedge clk_usr); #1;
            checks++; if (axis_out_tvalid !== 1'b0) begin failures++; $display("FAIL %s drop_tvalid got=%0b exp=0", name, axis_out_tvalid); end
         end
         checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s drop_done got=%0b exp=0", name, done); end
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s drop_busy got=%0b exp=0", name, busy); end
         checks++; if (pkts_sent !== 16'(exp_pk)) begin failures++; $display("FAIL %s drop_pkts_sent got=%0d exp=%0d", name, pkts_sent, exp_pk); end
         checks++; if (exp_pk != 1) begin failures++; $display("FAIL %s drop_pkt_count got=%0d exp=1", name, exp_pk); end
      end else begin
         checks++; if (exp_pk != n) begin failures++; $display("FAIL %s pkt_count got=%0d exp=%0d", name, exp_pk, n); end
         repeat (2) begin
            checks++; if (done !== 1'b1 || axis_out_tvalid !== 1'b0) begin failures++; $display("FAIL %s done_state got=%0b/%0b exp=1/0", name, done, axis_out_tvalid); end
            @(posedge clk_usr); #1;
         end
         checks++; if (pkts_sent !== 16'(n)) begin failures++; $display("FAIL %s pkts_sent got=%0d exp=%0d", name, pkts_sent, n); end
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s end_busy got=%0b exp=0", name, busy); end
         enable = 1'b0;
         @(posedge clk_usr); #1;
         checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s done_clear got=%0b exp=0", name, done); end
      end
      checks++; if (stall_cycles !== 32'(stalls)) begin failures++; $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stall_cycles, stalls); end
      if (rmode == 2) begin
         checks++; if (stall_cycles !== 32'd5) begin failures++; $display("FAIL %s stall_five got=%0d exp=5", name, stall_cycles); end
      end
   endtask

   task automatic test_reset();
      checks++; if ({axis_out_tvalid, axis_out_tlast, busy, done} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {axis_out_tvalid, axis_out_tlast, busy, done}); end
      checks++; if (axis_out_tdata !== '0 || axis_out_tid !== '0 || axis_out_tdest !== '0) begin failures++; $display("FAIL reset_payload got=%h/%0d/%0d exp=0", axis_out_tdata, axis_out_tid, axis_out_tdest); end
      checks++; if (pkts_sent !== '0 || stall_cycles !== '0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", pkts_sent, stall_cycles); end
      @(negedge clk_usr); rst_n = 1'b1;
      @(posedge clk_usr); #1;
      checks++; if (busy !== 1'b0 || axis_out_tvalid !== 1'b0) begin failures++; $display("FAIL idle_hold got=%0b/%0b exp=0/0", busy, axis_out_tvalid); end
   endtask

   task automatic test_basic();
      run_pkts("basic", 3, 4, 1'b0, 4'd5, 0, 0, -1);
   endtask

   task automatic test_backpressure();
      run_pkts("backpressure", 2, 2, 1'b0, 4'd9, 0, 2, -1);
   endtask

   task automatic test_rand_dest();
      run_pkts("rand_dest", 64, 2, 1'b1, 4'd0, 0, 1, -1);
   endtask

   task automatic test_edge_len();
      run_pkts("len0", 5, 0, 1'b1, 4'd0, 0, 1, -1);
      run_pkts("len31", 2, 31, 1'b0, 4'd12, 0, 1, -1);
      run_pkts("zero_pkts", 0, 4, 1'b0, 4'd1, 0, 0, -1);
   endtask

   task automatic test_enable_drop();
      run_pkts("enable_drop", 3, 4, 1'b0, 4'd7, 0, 0, 2);
      run_pkts("reenable", 2, 3, 1'b0, 4'd6, 0, 1, -1);
   endtask

   task automatic test_gap();
      run_pkts("gap3", 3, 2, 1'b0, 4'd1, 3, 1, -1);
   endtask

   task automatic test_reset_mid();
      num_packets = 16'd4; pkt_len = LW'(8); rand_dest = 1'b0; fixed_dest = 4'd2;
      gap_cycles = 8'd0; axis_out_tready = 1'b1; enable = 1'b1;
      repeat (5) @(posedge clk_usr);
      #1;
      checks++; if (axis_out_tvalid !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%0b exp=1", axis_out_tvalid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (axis_out_tvalid !== 1'b0) begin failures++; $display("FAIL rst_mid_tvalid got=%0b exp=0", axis_out_tvalid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%0b exp=0", busy); end
      enable = 1'b0;
      model_lfsr = 16'hACE1;
      @(negedge clk_usr); rst_n = 1'b1;
      run_pkts("post_reset", 2, 3, 1'b1, 4'd0, 0, 1, -1);
   endtask

   initial begin
      repeat (3) @(posedge clk_usr);
      #1;
      test_reset();
      test_basic();
      test_backpressure();
      test_rand_dest();
      test_edge_len();
      test_enable_drop();
      test_gap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
